// File: rtl/axonerve_kvs_ctrl_chain.sv
// axonerve_kvs_ctrl_chain
//   Kernel control sequencer between the SDx block-level handshake and up to
//   C_NUM_CHANNELS datapath channels. A start request launches every enabled
//   channel with a one-cycle pulse. The per-channel done pulses are combined
//   into one ap_done. The number of cycles spent in RUN is reported.
//
// Build option:
//   AXONERVE_KVS_CTRL_CHAIN_EN  defined   -> ap_ctrl_chain: ap_done is held
//                                            until ap_continue is sampled high
//                               undefined -> ap_ctrl_hs: ap_done is a single
//                                            pulse; ap_continue is unused
//
// Ports:
//   ap_clk       clock, rising edge
//   ap_rst_n     asynchronous active-low reset
//   ap_start     host start request (level), accepted only in IDLE
//   ap_continue  host acknowledge of ap_done (chain build only)
//   ap_idle      block idle
//   ap_ready     one-cycle pulse, start accepted and ch_enable sampled
//   ap_done      all enabled channels finished
//   ch_enable    channel enable mask, sampled when start is accepted
//   ch_start     one-cycle start pulse per enabled channel
//   ch_done      one-cycle done pulse per channel
//   run_cycles   cycles spent in RUN for the last/current run (saturating)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for ap_start; done_r tracks ~ch_enable
// LAUNCH | one cycle: ch_start/ap_ready pulse, run_cycles cleared
// RUN    | collecting ch_done pulses, counting cycles
// DONE   | chain build only: ap_done held until ap_continue

module axonerve_kvs_ctrl_chain #(
  parameter int C_NUM_CHANNELS    = 4,
  parameter int C_CYCLE_CNT_WIDTH = 48
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  input  logic                         ap_continue,
  output logic                         ap_idle,
  output logic                         ap_ready,
  output logic                         ap_done,
  input  logic [C_NUM_CHANNELS-1:0]    ch_enable,
  output logic [C_NUM_CHANNELS-1:0]    ch_start,
  input  logic [C_NUM_CHANNELS-1:0]    ch_done,
  output logic [C_CYCLE_CNT_WIDTH-1:0] run_cycles
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
`ifdef AXONERVE_KVS_CTRL_CHAIN_EN
  localparam logic [1:0] S_DONE   = 2'd3;
`endif

  localparam logic [C_CYCLE_CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [1:0]                state;
  logic [C_NUM_CHANNELS-1:0] en_r;
  logic [C_NUM_CHANNELS-1:0] done_r;
  logic [C_NUM_CHANNELS-1:0] done_next;
  logic                      all_done;

  // Disabled channels are preset as done, so only enabled channels can
  // hold off completion. Pulses from disabled channels are masked here.
  assign done_next = done_r | (ch_done & en_r);
  assign all_done  = &done_next;

`ifndef AXONERVE_KVS_CTRL_CHAIN_EN
  logic unused_continue;
  assign unused_continue = ap_continue;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      ap_idle    <= 1'b1;
      ap_ready   <= 1'b0;
      ap_done    <= 1'b0;
      ch_start   <= '0;
      run_cycles <= '0;
      en_r       <= '0;
      done_r     <= '0;
    end else begin
      ap_ready <= 1'b0;
      ch_start <= '0;
`ifndef AXONERVE_KVS_CTRL_CHAIN_EN
      ap_done  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          done_r <= ~ch_enable;
          if (ap_start) begin
            en_r       <= ch_enable;
            ch_start   <= ch_enable;
            ap_ready   <= 1'b1;
            ap_idle    <= 1'b0;
            run_cycles <= '0;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // ch_done is not looked at here; an empty mask completes at once.
          if (en_r == '0) begin
            ap_done <= 1'b1;
`ifdef AXONERVE_KVS_CTRL_CHAIN_EN
            state   <= S_DONE;
`else
            ap_idle <= 1'b1;
            state   <= S_IDLE;
`endif
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          done_r <= done_next;
          if (run_cycles != '1) begin
            run_cycles <= run_cycles + CNT_ONE;
          end
          if (all_done) begin
            ap_done <= 1'b1;
`ifdef AXONERVE_KVS_CTRL_CHAIN_EN
            state   <= S_DONE;
`else
            ap_idle <= 1'b1;
            state   <= S_IDLE;
`endif
          end
        end
`ifdef AXONERVE_KVS_CTRL_CHAIN_EN
        S_DONE: begin
          if (ap_continue) begin
            ap_done <= 1'b0;
            ap_idle <= 1'b1;
            state   <= S_IDLE;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axonerve_kvs_ctrl_chain.sv
// Testbench for axonerve_kvs_ctrl_chain (4 channels, 48-bit counter).
// Stimulus pushes the expected ap_ready and ap_done events into queues; a
// monitor on the falling edge pops and compares whenever the DUT shows them.
// Cycle numbering: "cycle c" of a run is the interval after edge c-1, where
// edge 0 is the edge that samples ap_start.

module tb_axonerve_kvs_ctrl_chain;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_continue;
  logic        ap_idle;
  logic        ap_ready;
  logic        ap_done;
  logic [3:0]  ch_enable;
  logic [3:0]  ch_start;
  logic [3:0]  ch_done;
  logic [47:0] run_cycles;

  axonerve_kvs_ctrl_chain #(
    .C_NUM_CHANNELS   (4),
    .C_CYCLE_CNT_WIDTH(48)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .ap_start   (ap_start),
    .ap_continue(ap_continue),
    .ap_idle    (ap_idle),
    .ap_ready   (ap_ready),
    .ap_done    (ap_done),
    .ch_enable  (ch_enable),
    .ch_start   (ch_start),
    .ch_done    (ch_done),
    .run_cycles (run_cycles)
  );

  always #5 ap_clk = ~ap_clk;

`ifdef AXONERVE_KVS_CTRL_CHAIN_EN
  localparam logic IDLE_AT_DONE = 1'b0;
`else
  localparam logic IDLE_AT_DONE = 1'b1;
`endif

  typedef struct {
    int          cyc;
    logic [3:0]  vec;
    logic [47:0] run;
  } exp_t;

  exp_t ready_q[$];
  exp_t done_q[$];

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every ap_ready pulse and every rising ap_done against
  // the head of its queue.
  logic prev_done = 1'b0;
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n) begin
      if (ap_ready) begin
        compared++;
        if (ready_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_ready: cycle %0d ch_start=%b", cyc, ch_start);
        end else begin
          e = ready_q.pop_front();
          if (cyc != e.cyc || ch_start !== e.vec || ap_idle !== 1'b0) begin
            mismatched++;
            $display("FAIL ready_event: got cycle %0d ch_start=%b idle=%b expected cycle %0d ch_start=%b idle=0",
                     cyc, ch_start, ap_idle, e.cyc, e.vec);
          end
        end
      end else if (ch_start != 4'b0000) begin
        compared++;
        mismatched++;
        $display("FAIL stray_ch_start: got %b expected 0000 (cycle %0d)", ch_start, cyc);
      end
      if (ap_done && !prev_done) begin
        compared++;
        if (done_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_done: cycle %0d run_cycles=%0d", cyc, run_cycles);
        end else begin
          e = done_q.pop_front();
          if (cyc != e.cyc || run_cycles !== e.run || ap_idle !== IDLE_AT_DONE) begin
            mismatched++;
            $display("FAIL done_event: got cycle %0d run=%0d idle=%b expected cycle %0d run=%0d idle=%b",
                     cyc, run_cycles, ap_idle, e.cyc, e.run, IDLE_AT_DONE);
          end
        end
      end
      prev_done = ap_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // One run: start at edge 0, dn[e] is the ch_done vector sampled at edge e.
  task automatic run_test(input logic [3:0] en, input logic [15:0][3:0] dn,
                          input int n_edges, input int done_cycle, input logic [47:0] exp_run);
    int   g0;
    exp_t e;
    @(negedge ap_clk);
    g0 = cyc + 1;
    e.cyc = g0;                  e.vec = en; e.run = '0;
    ready_q.push_back(e);
    e.cyc = g0 + done_cycle - 1; e.vec = '0; e.run = exp_run;
    done_q.push_back(e);
    ch_enable = en;
    for (int i = 0; i < n_edges; i++) begin
      ap_start = (i == 0);
      ch_done  = dn[i];
      @(negedge ap_clk);
    end
    ap_start = 1'b0;
    ch_done  = '0;
    repeat (3) @(negedge ap_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0][3:0] dn;
    int               g0;
    exp_t             e;

    ap_rst_n    = 1'b0;
    ap_start    = 1'b0;
    ap_continue = 1'b1;
    ch_enable   = '0;
    ch_done     = '0;
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("reset_idle",     {63'd0, ap_idle},  64'd1);
    check("reset_ready",    {63'd0, ap_ready}, 64'd0);
    check("reset_done",     {63'd0, ap_done},  64'd0);
    check("reset_ch_start", {60'd0, ch_start}, 64'd0);
    check("reset_run",      {16'd0, run_cycles}, 64'd0);

    // All four channels, done at edges 3, 5, 5, 9.
    dn = '0; dn[3] = 4'b0001; dn[5] = 4'b0110; dn[9] = 4'b1000;
    run_test(4'b1111, dn, 10, 10, 48'd8);

    // Sparse mask with stray pulses on disabled channels.
    dn = '0; dn[2] = 4'b1010; dn[3] = 4'b1010; dn[4] = 4'b0001; dn[6] = 4'b0100;
    run_test(4'b0101, dn, 7, 7, 48'd5);

    // Empty mask.
    dn = '0;
    run_test(4'b0000, dn, 1, 2, 48'd0);

    // Repeat pulse on an already-done channel.
    dn = '0; dn[2] = 4'b0001; dn[3] = 4'b0001; dn[5] = 4'b0010;
    run_test(4'b0011, dn, 6, 6, 48'd4);

    // All channels done in the same cycle, earliest legal edge.
    dn = '0; dn[2] = 4'b1111;
    run_test(4'b1111, dn, 3, 3, 48'd1);

`ifdef AXONERVE_KVS_CTRL_CHAIN_EN
    // ap_done held while ap_continue is low; ap_start ignored meanwhile.
    ap_continue = 1'b0;
    dn = '0; dn[2] = 4'b0001;
    run_test(4'b0001, dn, 3, 3, 48'd1);
    for (int i = 0; i < 20; i++) begin
      check("chain_hold_done", {63'd0, ap_done}, 64'd1);
      check("chain_hold_idle", {63'd0, ap_idle}, 64'd0);
      if (i == 5)  ap_start = 1'b1;
      if (i == 12) ap_start = 1'b0;
      @(negedge ap_clk);
    end
    ap_continue = 1'b1;
    @(negedge ap_clk);
    check("chain_release_done", {63'd0, ap_done}, 64'd0);
    check("chain_release_idle", {63'd0, ap_idle}, 64'd1);
    repeat (2) @(negedge ap_clk);
`endif

    // Reset mid-run after two of four channels are done.
    @(negedge ap_clk);
    g0 = cyc + 1;
    e.cyc = g0; e.vec = 4'b1111; e.run = '0;
    ready_q.push_back(e);
    ch_enable = 4'b1111;
    ap_start  = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    @(negedge ap_clk);
    ch_done = 4'b0011;
    @(negedge ap_clk);
    ch_done = '0;
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    check("abort_idle", {63'd0, ap_idle},    64'd1);
    check("abort_done", {63'd0, ap_done},    64'd0);
    check("abort_run",  {16'd0, run_cycles}, 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    // Fresh run must wait for all four channels again.
    dn = '0; dn[3] = 4'b0011; dn[4] = 4'b0100; dn[6] = 4'b1000;
    run_test(4'b1111, dn, 7, 7, 48'd5);

    for (int i = 0; i < 50 && (ready_q.size() != 0 || done_q.size() != 0); i++) begin
      @(negedge ap_clk);
    end
    while (ready_q.size() != 0) begin
      e = ready_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_ready: no ap_ready observed, expected at cycle %0d", e.cyc);
    end
    while (done_q.size() != 0) begin
      e = done_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_done: no ap_done observed, expected at cycle %0d", e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
